// File: rtl/aes_iter_core.sv
// aes_iter_core: iterative AES-128/192/256 encrypt/decrypt round engine, one round per clock, valid/ready on both sides
module aes_iter_core #(
    parameter int NK = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [127:0]          in_data,
    input  logic                  mode,
    input  logic [128*(NK+7)-1:0] key_sched,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [127:0]          out_data,
    output logic                  busy
);
    localparam int NR  = NK + 6;
    localparam int KSW = 128 * (NK + 7);

    typedef enum logic [1:0] {IDLE, ROUND, DONE} fsm_t;

    fsm_t         fsm_q;
    logic [3:0]   rnd_q;
    logic [127:0] st_q, st_d, out_data_q, rk_r, rk_in, enc_sr, dec_ark;
    logic         mode_q, out_valid_q, in_ready_q, busy_q, last;
    int           rk_idx;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            p = b[i] ? p ^ x : p;
            x = xtime(x);
        end
        return p;
    endfunction

    // a^254 is the multiplicative inverse in GF(2^8); 0 maps to 0 as the S-box requires
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] p, r;
        p = a;
        r = 8'h01;
        for (int i = 1; i < 8; i++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [7:0] x;
        x = gf_inv(b);
        return x ^ rotl(x, 1) ^ rotl(x, 2) ^ rotl(x, 3) ^ rotl(x, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        return gf_inv(rotl(b, 1) ^ rotl(b, 3) ^ rotl(b, 6) ^ 8'h05);
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] s, input logic inv);
        logic [127:0] o;
        for (int i = 0; i < 16; i++)
            o[127-8*i -: 8] = inv ? inv_sbox(s[127-8*i -: 8]) : sbox(s[127-8*i -: 8]);
        return o;
    endfunction

    // byte i sits at row i%4, column i/4; row r rotates left by r (right by r for the inverse)
    function automatic logic [127:0] shift_rows(input logic [127:0] s, input logic inv);
        logic [127:0] o;
        int r, c, src;
        for (int i = 0; i < 16; i++) begin
            r   = i % 4;
            c   = i / 4;
            src = inv ? (c - r + 4) % 4 : (c + r) % 4;
            o[127-8*i -: 8] = s[127-8*(r+4*src) -: 8];
        end
        return o;
    endfunction

    // circulant column matrix {02,03,01,01} forward, {0e,0b,0d,09} inverse
    function automatic logic [127:0] mix_columns(input logic [127:0] s, input logic inv);
        logic [127:0]     o;
        logic [3:0][7:0]  a, coef;
        logic [7:0]       acc;
        coef = inv ? {8'h09, 8'h0d, 8'h0b, 8'h0e} : {8'h01, 8'h01, 8'h03, 8'h02};
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) a[r] = s[127-8*(4*c+r) -: 8];
            for (int r = 0; r < 4; r++) begin
                acc = 8'h00;
                for (int j = 0; j < 4; j++) acc = acc ^ gf_mul(a[j], coef[(j-r+4)%4]);
                o[127-8*(4*c+r) -: 8] = acc;
            end
        end
        return o;
    endfunction

    // round datapath: key selection plus one encrypt or decrypt round on the state register
    always_comb begin
        last    = (rnd_q == 4'(NR));
        rk_idx  = mode_q ? NR - int'(rnd_q) : int'(rnd_q);
        rk_r    = key_sched[KSW-1-128*rk_idx -: 128];
        rk_in   = mode ? key_sched[127:0] : key_sched[KSW-1 -: 128];
        enc_sr  = shift_rows(sub_bytes(st_q, 1'b0), 1'b0);
        dec_ark = sub_bytes(shift_rows(st_q, 1'b1), 1'b1) ^ rk_r;
        st_d    = mode_q ? (last ? dec_ark : mix_columns(dec_ark, 1'b1))
                         : ((last ? enc_sr : mix_columns(enc_sr, 1'b0)) ^ rk_r);
    end

    // control FSM with registered handshake outputs; accept, iterate NR rounds, hold result until taken
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fsm_q       <= IDLE;
            rnd_q       <= '0;
            st_q        <= '0;
            mode_q      <= 1'b0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            case (fsm_q)
                IDLE: if (in_valid) begin
                    mode_q     <= mode;
                    st_q       <= in_data ^ rk_in;
                    rnd_q      <= 4'd1;
                    fsm_q      <= ROUND;
                    in_ready_q <= 1'b0;
                    busy_q     <= 1'b1;
                end
                ROUND: if (last) begin
                    out_data_q  <= st_d;
                    out_valid_q <= 1'b1;
                    fsm_q       <= DONE;
                end else begin
                    st_q  <= st_d;
                    rnd_q <= rnd_q + 4'd1;
                end
                DONE: if (out_ready) begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    busy_q      <= 1'b0;
                    fsm_q       <= IDLE;
                end
                default: fsm_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign busy      = busy_q;
endmodule

// File: tb/tb_aes_iter_core.sv
// tb_aes_iter_core: directed + randomized checks of aes_iter_core for NK=4/6/8 against a table-driven AES model
module tb_aes_iter_core;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [127:0]        dat;
    logic                md;
    logic [2:0]          iv, ordy, ir, ov, bz;
    logic [2:0][127:0]   od;
    logic [2:0][1919:0]  ks;

    for (genvar g = 0; g < 3; g++) begin : u
        aes_iter_core #(.NK(4 + 2*g)) dut (
            .clk(clk), .rst_n(rst_n), .in_valid(iv[g]), .in_ready(ir[g]), .in_data(dat), .mode(md),
            .key_sched(ks[g][128*(11+2*g)-1:0]), .out_valid(ov[g]), .out_ready(ordy[g]),
            .out_data(od[g]), .busy(bz[g]));
    end

    int n_pass = 0, n_tot = 0;
    logic [7:0] sb[256], isb[256];

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tot++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic hi;
        p = 0;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p ^= a;
            hi = a[7];
            a = a << 1;
            if (hi) a ^= 8'h1b;
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [31:0] mc(input logic [7:0] a0, a1, a2, a3, input logic inv);
        if (inv)
            return {gm(a0,14)^gm(a1,11)^gm(a2,13)^gm(a3,9), gm(a0,9)^gm(a1,14)^gm(a2,11)^gm(a3,13),
                    gm(a0,13)^gm(a1,9)^gm(a2,14)^gm(a3,11), gm(a0,11)^gm(a1,13)^gm(a2,9)^gm(a3,14)};
        return {gm(a0,2)^gm(a1,3)^a2^a3, a0^gm(a1,2)^gm(a2,3)^a3,
                a0^a1^gm(a2,2)^gm(a3,3), gm(a0,3)^a1^a2^gm(a3,2)};
    endfunction

    function automatic logic [1919:0] expand(input int nk, input logic [255:0] key);
        logic [31:0] w[60];
        logic [31:0] t;
        logic [7:0] rc;
        logic [1919:0] k;
        int kw;
        kw = 128*(nk+7); rc = 8'h01; k = '0;
        for (int i = 0; i < 4*(nk+7); i++) begin
            if (i < nk) w[i] = key[255-32*i -: 32];
            else begin
                t = w[i-1];
                if (i % nk == 0) begin
                    t = {sb[t[23:16]], sb[t[15:8]], sb[t[7:0]], sb[t[31:24]]} ^ {rc, 24'h0};
                    rc = gm(rc, 8'h02);
                end else if (nk > 6 && i % nk == 4)
                    t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
                w[i] = w[i-nk] ^ t;
            end
            k[kw-1-32*i -: 32] = w[i];
        end
        return k;
    endfunction

    function automatic logic [127:0] m_enc(input int nk, input logic [1919:0] k, input logic [127:0] pt);
        int nr, kw;
        logic [7:0] s[16], t[16];
        logic [127:0] rk, o;
        nr = nk + 6; kw = 128*(nk+7);
        rk = k[kw-1 -: 128];
        for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ rk[127-8*i -: 8];
        for (int n = 1; n <= nr; n++) begin
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++) t[r+4*c] = sb[s[r+4*((c+r)%4)]];
            for (int c = 0; c < 4; c++)
                if (n < nr) {s[4*c], s[4*c+1], s[4*c+2], s[4*c+3]} = mc(t[4*c], t[4*c+1], t[4*c+2], t[4*c+3], 1'b0);
                else {s[4*c], s[4*c+1], s[4*c+2], s[4*c+3]} = {t[4*c], t[4*c+1], t[4*c+2], t[4*c+3]};
            rk = k[kw-1-128*n -: 128];
            for (int i = 0; i < 16; i++) s[i] ^= rk[127-8*i -: 8];
        end
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
        return o;
    endfunction

    function automatic logic [127:0] m_dec(input int nk, input logic [1919:0] k, input logic [127:0] ct);
        int nr, kw;
        logic [7:0] s[16], t[16];
        logic [127:0] rk, o;
        nr = nk + 6; kw = 128*(nk+7);
        rk = k[kw-1-128*nr -: 128];
        for (int i = 0; i < 16; i++) s[i] = ct[127-8*i -: 8] ^ rk[127-8*i -: 8];
        for (int n = nr - 1; n >= 0; n--) begin
            rk = k[kw-1-128*n -: 128];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++) t[r+4*c] = isb[s[r+4*((c-r+4)%4)]] ^ rk[127-8*(r+4*c) -: 8];
            for (int c = 0; c < 4; c++)
                if (n > 0) {s[4*c], s[4*c+1], s[4*c+2], s[4*c+3]} = mc(t[4*c], t[4*c+1], t[4*c+2], t[4*c+3], 1'b1);
                else {s[4*c], s[4*c+1], s[4*c+2], s[4*c+3]} = {t[4*c], t[4*c+1], t[4*c+2], t[4*c+3]};
        end
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
        return o;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic wait_ov(input int g, output int lat);
        lat = 0;
        while (!ov[g] && lat < 40) begin
            tick();
            lat++;
        end
        check("out_valid_rise", 128'(ov[g]), 128'd1);
    endtask

    // one full transaction; mode and in_data are scrambled while the rounds run
    task automatic run(input int g, input logic [127:0] din, input logic m, output logic [127:0] dout, output int lat);
        iv[g] = 1'b1; dat = din; md = m;
        tick();
        iv[g] = 1'b0;
        check("accept_busy", 128'(bz[g]), 128'd1);
        check("round_in_ready", 128'(ir[g]), 128'd0);
        md = ~m; dat = ~din;
        wait_ov(g, lat);
        dout = od[g];
        ordy[g] = 1'b1;
        tick();
        ordy[g] = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [255:0] fkey;
        logic [127:0] pt, ct, res, held, p2, exp_q[4], blk[4];
        logic [127:0] fct[3];
        logic [7:0] inv, s;
        int lat, n;
        fkey = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
        pt   = 128'h00112233445566778899aabbccddeeff;
        fct[0] = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
        fct[1] = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
        fct[2] = 128'h8ea2b7ca516745bfeafc49904b496089;
        for (int x = 0; x < 256; x++) begin
            inv = 0;
            for (int y = 1; y < 256; y++) if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            for (int b = 0; b < 8; b++)
                s[b] = inv[b] ^ inv[(b+4)%8] ^ inv[(b+5)%8] ^ inv[(b+6)%8] ^ inv[(b+7)%8] ^ ((8'h63 >> b) & 1'b1);
            sb[x] = s;
            isb[s] = 8'(x);
        end
        iv = 0; ordy = 0; dat = 0; md = 0;
        for (int g = 0; g < 3; g++) ks[g] = expand(4 + 2*g, fkey);

        tick(); tick();
        for (int g = 0; g < 3; g++) begin
            check("rst_out_valid", 128'(ov[g]), 128'd0);
            check("rst_in_ready", 128'(ir[g]), 128'd1);
            check("rst_busy", 128'(bz[g]), 128'd0);
            check("rst_out_data", od[g], 128'd0);
        end
        rst_n = 1'b1;
        tick();

        // FIPS-197 known answers for each key length, both directions
        for (int g = 0; g < 3; g++) begin
            run(g, pt, 1'b0, res, lat);
            check("fips_enc", res, fct[g]);
            check("fips_enc_latency", 128'(lat), 128'(10 + 2*g));
            run(g, fct[g], 1'b1, res, lat);
            check("fips_dec", res, pt);
            check("fips_dec_latency", 128'(lat), 128'(10 + 2*g));
        end

        // random keys and blocks against the model
        for (int g = 0; g < 3; g++)
            for (int k = 0; k < 3; k++) begin
                ks[g] = expand(4 + 2*g, {rnd128(), rnd128()});
                p2 = rnd128();
                run(g, p2, 1'b0, res, lat);
                check("rand_enc", res, m_enc(4 + 2*g, ks[g], p2));
                p2 = rnd128();
                run(g, p2, 1'b1, res, lat);
                check("rand_dec", res, m_dec(4 + 2*g, ks[g], p2));
            end

        // backpressure on NK=8: result held, upstream pulses ignored
        p2 = rnd128();
        iv[2] = 1'b1; dat = p2; md = 1'b0;
        tick();
        iv[2] = 1'b0;
        wait_ov(2, lat);
        held = m_enc(8, ks[2], p2);
        check("bp_result", od[2], held);
        for (int i = 0; i < 20; i++) begin
            iv[2] = i[0]; dat = rnd128(); md = $urandom_range(1);
            tick();
            check("bp_hold_data", od[2], held);
            check("bp_in_ready", 128'(ir[2]), 128'd0);
            check("bp_out_valid", 128'(ov[2]), 128'd1);
        end
        iv[2] = 1'b0; ordy[2] = 1'b1;
        tick();
        ordy[2] = 1'b0;
        check("bp_release_valid", 128'(ov[2]), 128'd0);
        check("bp_release_ready", 128'(ir[2]), 128'd1);
        check("bp_release_busy", 128'(bz[2]), 128'd0);
        p2 = rnd128();
        iv[2] = 1'b1; dat = p2; md = 1'b1;
        tick();
        iv[2] = 1'b0;
        check("bp_next_accept", 128'(bz[2]), 128'd1);
        wait_ov(2, lat);
        check("bp_next_result", od[2], m_dec(8, ks[2], p2));
        ordy[2] = 1'b1;
        tick();
        ordy[2] = 1'b0;

        // back-to-back alternating modes with handshakes tied high
        for (int k = 0; k < 4; k++) begin
            blk[k] = rnd128();
            exp_q[k] = k[0] ? m_dec(8, ks[2], blk[k]) : m_enc(8, ks[2], blk[k]);
        end
        iv[2] = 1'b1; ordy[2] = 1'b1; dat = blk[0]; md = 1'b0;
        for (int k = 0; k < 4; k++) begin
            n = 0;
            while (!bz[2] && n < 40) begin
                tick();
                n++;
            end
            check("b2b_accept_gap", 128'(n), 128'd1);
            if (k < 3) begin
                dat = blk[k+1]; md = ~md;
            end else begin
                iv[2] = 1'b0; dat = rnd128(); md = ~md;
            end
            wait_ov(2, lat);
            check("b2b_latency", 128'(lat), 128'd14);
            check("b2b_result", od[2], exp_q[k]);
            tick();
            check("b2b_done_exit", 128'(ov[2]), 128'd0);
        end
        ordy[2] = 1'b0;

        // reset in the middle of round 5 discards the block
        iv[2] = 1'b1; dat = rnd128(); md = 1'b0;
        tick();
        iv[2] = 1'b0;
        repeat (4) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("midrst_out_valid", 128'(ov[2]), 128'd0);
        check("midrst_out_data", od[2], 128'd0);
        check("midrst_in_ready", 128'(ir[2]), 128'd1);
        check("midrst_busy", 128'(bz[2]), 128'd0);
        repeat (16) tick();
        check("midrst_no_output", 128'(ov[2]), 128'd0);
        p2 = rnd128();
        run(2, p2, 1'b0, res, lat);
        check("midrst_fresh_result", res, m_enc(8, ks[2], p2));
        check("midrst_fresh_latency", 128'(lat), 128'd14);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
